// File: rtl/snn_post_pkg.sv
// Shared types and constant helpers for the post-synaptic trace buffer.
package snn_post_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } post_state_t;

   // All-ones value of a trace of the given width (the value a spike sets).
   function automatic logic [63:0] trace_ones(input int width);
      return (64'd1 << width) - 64'd1;
   endfunction

   // Largest value a saturating counter of the given width may hold.
   function automatic logic [63:0] cnt_max(input int width);
      return (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/post_trace_decay.sv
// Combinational trace datapath: clear on init, set on spike, else exponential decay by shift.
module post_trace_decay
   import snn_post_pkg::*;
#(
   parameter int TRACE_W = 16,
   parameter int SHIFT   = 4
) (
   input  logic [TRACE_W-1:0] i_y,
   input  logic               i_spike,
   input  logic               i_init,
   output logic [TRACE_W-1:0] o_y
);

   localparam logic [TRACE_W-1:0] ONES = TRACE_W'(trace_ones(TRACE_W));

   logic [TRACE_W-1:0] w_decayed;

   // y >> SHIFT never exceeds y, so the subtraction cannot wrap.
   assign w_decayed = i_y - (i_y >> SHIFT);

   always_comb begin
      if (i_init) begin
         o_y = '0;
      end else if (i_spike) begin
         o_y = ONES;
      end else begin
         o_y = w_decayed;
      end
   end

endmodule

// File: rtl/post_trace_buffer.sv
// Per-neuron post-synaptic state buffer: STDP traces, spike counters, frame sequencing.
// Optional winner-take-all outputs are built when POST_WTA_EN is defined.
module post_trace_buffer
   import snn_post_pkg::*;
#(
   parameter int N_NEURON   = 18,
   parameter int TRACE_W    = 16,
   parameter int CNT_W      = 7,
   parameter int TAU1_SHIFT = 4,
   parameter int TAU2_SHIFT = 5,
   localparam int IDX_W     = $clog2(N_NEURON)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_valid,
   input  logic [IDX_W-1:0]            i_idx,
   input  logic                        i_spike,
   input  logic                        i_s_init,
   input  logic                        i_cnt_clr,
   output logic [N_NEURON-1:0]         o_spike_buf,
   output logic [N_NEURON*TRACE_W-1:0] o_y1_trace,
   output logic [N_NEURON*TRACE_W-1:0] o_y2_prev,
   output logic [N_NEURON*CNT_W-1:0]   o_post_cnt,
   output logic [IDX_W:0]              o_inhbt,
   output logic                        o_valid,
   output logic                        o_seq_err,
   output logic                        o_cnt_sat
`ifdef POST_WTA_EN
   ,
   output logic [IDX_W-1:0]            o_winner_idx,
   output logic                        o_winner_vld
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max(CNT_W));
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURON - 1);

   logic               r_s1_acc, r_s1_inr, r_s1_spike, r_s1_init, r_s1_clr;
   logic [IDX_W-1:0]   r_s1_idx;
   logic [TRACE_W-1:0] r_s1_y1, r_s1_y2;

   logic               r_s2_vld;
   logic [IDX_W-1:0]   r_s2_idx;
   logic [TRACE_W-1:0] r_s2_y1, r_s2_y2, r_s2_y2p;

   logic [TRACE_W-1:0] r_y1  [N_NEURON];
   logic [TRACE_W-1:0] r_y2  [N_NEURON];
   logic [TRACE_W-1:0] r_y2p [N_NEURON];
   logic [CNT_W-1:0]   r_cnt [N_NEURON];
   logic [N_NEURON-1:0] r_spike_buf;
   logic [IDX_W:0]     r_inhbt;

   post_state_t        r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_exp, w_exp_nxt;
   logic               w_seq_err, w_frame_done;
   logic               r_seq_err, r_valid_pend, r_valid;

   logic               w_in_range, w_s1_wr;
   logic [TRACE_W-1:0] w_y1_new, w_y2_new, w_y1_arr, w_y2_arr, w_y1_rd, w_y2_rd;

   assign w_in_range = ({1'b0, i_idx} < (IDX_W+1)'(N_NEURON));
   assign w_s1_wr    = r_s1_acc & r_s1_inr;

   always_comb begin
      w_y1_arr = '0;
      w_y2_arr = '0;
      for (int k = 0; k < N_NEURON; k++) begin
         if (i_idx == IDX_W'(k)) begin
            w_y1_arr = r_y1[k];
            w_y2_arr = r_y2[k];
         end
      end
   end

   // The array lags two accepts behind; take the newest in-flight value for the same neuron.
   always_comb begin
      if (w_s1_wr && (r_s1_idx == i_idx)) begin
         w_y1_rd = w_y1_new;
         w_y2_rd = w_y2_new;
      end else if (r_s2_vld && (r_s2_idx == i_idx)) begin
         w_y1_rd = r_s2_y1;
         w_y2_rd = r_s2_y2;
      end else begin
         w_y1_rd = w_y1_arr;
         w_y2_rd = w_y2_arr;
      end
   end

   post_trace_decay #(.TRACE_W(TRACE_W), .SHIFT(TAU1_SHIFT)) u_y1_decay (
      .i_y     (r_s1_y1),
      .i_spike (r_s1_spike),
      .i_init  (r_s1_init),
      .o_y     (w_y1_new)
   );

   post_trace_decay #(.TRACE_W(TRACE_W), .SHIFT(TAU2_SHIFT)) u_y2_decay (
      .i_y     (r_s1_y2),
      .i_spike (r_s1_spike),
      .i_init  (r_s1_init),
      .o_y     (w_y2_new)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_acc   <= 1'b0;
         r_s1_inr   <= 1'b0;
         r_s1_spike <= 1'b0;
         r_s1_init  <= 1'b0;
         r_s1_clr   <= 1'b0;
         r_s1_idx   <= '0;
         r_s1_y1    <= '0;
         r_s1_y2    <= '0;
         r_s2_vld   <= 1'b0;
         r_s2_idx   <= '0;
         r_s2_y1    <= '0;
         r_s2_y2    <= '0;
         r_s2_y2p   <= '0;
      end else begin
         r_s1_acc   <= i_valid;
         r_s1_inr   <= w_in_range;
         r_s1_spike <= i_spike;
         r_s1_init  <= i_s_init;
         r_s1_clr   <= i_cnt_clr;
         r_s1_idx   <= i_idx;
         r_s1_y1    <= w_y1_rd;
         r_s1_y2    <= w_y2_rd;
         r_s2_vld   <= w_s1_wr;
         r_s2_idx   <= r_s1_idx;
         r_s2_y1    <= w_y1_new;
         r_s2_y2    <= w_y2_new;
         r_s2_y2p   <= r_s1_init ? '0 : r_s1_y2;
      end
   end

   // NOTE: the trace arrays are plain flops, so they take the async reset like any other state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_NEURON; k++) begin
            r_y1[k]  <= '0;
            r_y2[k]  <= '0;
            r_y2p[k] <= '0;
         end
      end else if (r_s2_vld) begin
         for (int k = 0; k < N_NEURON; k++) begin
            if (r_s2_idx == IDX_W'(k)) begin
               r_y1[k]  <= r_s2_y1;
               r_y2[k]  <= r_s2_y2;
               r_y2p[k] <= r_s2_y2p;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_NEURON; k++) r_cnt[k] <= '0;
         r_spike_buf <= '0;
         r_inhbt     <= '0;
      end else begin
         for (int k = 0; k < N_NEURON; k++) begin
            if (r_s1_clr) begin
               r_cnt[k] <= '0;
            end else if (w_s1_wr && r_s1_spike && (r_s1_idx == IDX_W'(k)) && (r_cnt[k] != CNT_MAX)) begin
               r_cnt[k] <= r_cnt[k] + CNT_W'(1);
            end
            if (w_s1_wr && (r_s1_idx == IDX_W'(k))) r_spike_buf[k] <= r_s1_spike;
         end
         if (w_s1_wr) begin
            if (r_s1_idx == '0) begin
               r_inhbt <= (IDX_W+1)'(r_s1_spike);
            end else if (r_s1_spike) begin
               r_inhbt <= r_inhbt + (IDX_W+1)'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_exp   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_exp   <= w_exp_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_exp_nxt   = r_exp;
      if (r_s1_acc) begin
         if (!r_s1_inr) begin
            w_state_nxt = IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (r_s1_idx == '0) begin
                     w_state_nxt = COLLECT;
                     w_exp_nxt   = IDX_W'(1);
                  end
               end
               COLLECT: begin
                  if (r_s1_idx == r_exp) begin
                     if (r_s1_idx == LAST_IDX) w_state_nxt = IDLE;
                     else                      w_exp_nxt   = r_exp + IDX_W'(1);
                  end else if (r_s1_idx == '0) begin
                     w_exp_nxt = IDX_W'(1);
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end
               default: w_state_nxt = IDLE;
            endcase
         end
      end
   end

   always_comb begin
      w_seq_err    = 1'b0;
      w_frame_done = 1'b0;
      if (r_s1_acc) begin
         if (!r_s1_inr) begin
            w_seq_err = 1'b1;
         end else if (r_state == IDLE) begin
            w_seq_err = (r_s1_idx != '0);
         end else if (r_s1_idx == r_exp) begin
            w_frame_done = (r_s1_idx == LAST_IDX);
         end else begin
            w_seq_err = 1'b1;
         end
      end
   end

   // The done strobe waits one more edge so it lines up with the last trace write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seq_err    <= 1'b0;
         r_valid_pend <= 1'b0;
         r_valid      <= 1'b0;
      end else begin
         r_seq_err    <= w_seq_err;
         r_valid_pend <= w_frame_done;
         r_valid      <= r_valid_pend;
      end
   end

`ifdef POST_WTA_EN
   logic [IDX_W-1:0] r_win_idx, w_win_idx;
   logic             r_win_vld, w_win_any;

   always_comb begin
      w_win_idx = '0;
      w_win_any = 1'b0;
      for (int k = N_NEURON - 1; k >= 0; k--) begin
         if (r_spike_buf[k]) begin
            w_win_idx = IDX_W'(k);
            w_win_any = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win_idx <= '0;
         r_win_vld <= 1'b0;
      end else if (r_valid_pend) begin
         r_win_idx <= w_win_idx;
         r_win_vld <= w_win_any;
      end
   end

   assign o_winner_idx = r_win_idx;
   assign o_winner_vld = r_win_vld;
`endif

   for (genvar k = 0; k < N_NEURON; k++) begin : g_out
      assign o_y1_trace[k*TRACE_W +: TRACE_W] = r_y1[k];
      assign o_y2_prev[k*TRACE_W +: TRACE_W]  = r_y2p[k];
      assign o_post_cnt[k*CNT_W +: CNT_W]     = r_cnt[k];
   end

   always_comb begin
      o_cnt_sat = 1'b0;
      for (int k = 0; k < N_NEURON; k++) begin
         if (r_cnt[k] == CNT_MAX) o_cnt_sat = 1'b1;
      end
   end

   assign o_spike_buf = r_spike_buf;
   assign o_inhbt     = r_inhbt;
   assign o_valid     = r_valid;
   assign o_seq_err   = r_seq_err;

endmodule

// File: tb/tb_post_trace_buffer.sv
// Directed self-checking bench for post_trace_buffer (default parameters).
module tb_post_trace_buffer;

   localparam int N       = 18;
   localparam int TRACE_W = 16;
   localparam int CNT_W   = 7;
   localparam int IDX_W   = 5;

   logic                 clk;
   logic                 rst_n;
   logic                 i_valid;
   logic [IDX_W-1:0]     i_idx;
   logic                 i_spike;
   logic                 i_s_init;
   logic                 i_cnt_clr;
   logic [N-1:0]         o_spike_buf;
   logic [N*TRACE_W-1:0] o_y1_trace;
   logic [N*TRACE_W-1:0] o_y2_prev;
   logic [N*CNT_W-1:0]   o_post_cnt;
   logic [IDX_W:0]       o_inhbt;
   logic                 o_valid;
   logic                 o_seq_err;
   logic                 o_cnt_sat;
`ifdef POST_WTA_EN
   logic [IDX_W-1:0]     o_winner_idx;
   logic                 o_winner_vld;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int valid_seen = 0;
   int err_seen = 0;
   int exp_valid = 0;
   int exp_err = 0;

   post_trace_buffer #(
      .N_NEURON(N), .TRACE_W(TRACE_W), .CNT_W(CNT_W), .TAU1_SHIFT(4), .TAU2_SHIFT(5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_valid     (i_valid),
      .i_idx       (i_idx),
      .i_spike     (i_spike),
      .i_s_init    (i_s_init),
      .i_cnt_clr   (i_cnt_clr),
      .o_spike_buf (o_spike_buf),
      .o_y1_trace  (o_y1_trace),
      .o_y2_prev   (o_y2_prev),
      .o_post_cnt  (o_post_cnt),
      .o_inhbt     (o_inhbt),
      .o_valid     (o_valid),
      .o_seq_err   (o_seq_err),
      .o_cnt_sat   (o_cnt_sat)
`ifdef POST_WTA_EN
      ,
      .o_winner_idx(o_winner_idx),
      .o_winner_vld(o_winner_vld)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe counters sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_valid)   valid_seen++;
         if (o_seq_err) err_seen++;
      end
   end

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [TRACE_W-1:0] y1_of(input int k);
      return o_y1_trace[k*TRACE_W +: TRACE_W];
   endfunction

   function automatic logic [TRACE_W-1:0] y2p_of(input int k);
      return o_y2_prev[k*TRACE_W +: TRACE_W];
   endfunction

   function automatic logic [CNT_W-1:0] cnt_of(input int k);
      return o_post_cnt[k*CNT_W +: CNT_W];
   endfunction

   task automatic drive(input int idx, input logic spk, input logic init, input logic clr);
      i_valid   = 1'b1;
      i_idx     = IDX_W'(idx);
      i_spike   = spk;
      i_s_init  = init;
      i_cnt_clr = clr;
      @(posedge clk); #1;
   endtask

   task automatic idle_cycles(input int n);
      i_valid   = 1'b0;
      i_spike   = 1'b0;
      i_s_init  = 1'b0;
      i_cnt_clr = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_frame(input logic [N-1:0] mask);
      for (int i = 0; i < N; i++) drive(i, mask[i], 1'b0, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_spike_buf"}, o_spike_buf, 0);
      check({tag, "_y1"},        o_y1_trace,  0);
      check({tag, "_y2_prev"},   o_y2_prev,   0);
      check({tag, "_cnt"},       o_post_cnt,  0);
      check({tag, "_inhbt"},     o_inhbt,     0);
      check({tag, "_valid"},     o_valid,     0);
      check({tag, "_seq_err"},   o_seq_err,   0);
      check({tag, "_cnt_sat"},   o_cnt_sat,   0);
`ifdef POST_WTA_EN
      check({tag, "_win_idx"},   o_winner_idx, 0);
      check({tag, "_win_vld"},   o_winner_vld, 0);
`endif
   endtask

   initial begin
      logic [N*CNT_W-1:0] sat_vec;
      logic [N-1:0]       mask;

      rst_n = 1'b0;
      i_valid = 1'b0; i_idx = '0; i_spike = 1'b0; i_s_init = 1'b0; i_cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Frame 1: spike only at idx 3, with strobe timing around the last accept.
      mask = '0; mask[3] = 1'b1;
      send_frame(mask);
      check("f1_valid_t0", o_valid, 0);
      idle_cycles(1);
      check("f1_valid_t1", o_valid, 0);
      check("f1_inhbt", o_inhbt, 1);
      idle_cycles(1);
      check("f1_valid_t2", o_valid, 1);
      check("f1_y1_3", y1_of(3), 16'hFFFF);
      idle_cycles(1);
      check("f1_valid_t3", o_valid, 0);
      check("f1_y2p_3", y2p_of(3), 16'h0000);
      check("f1_spike_buf", o_spike_buf, 18'h00008);
      check("f1_cnt_3", cnt_of(3), 1);
      exp_valid = 1;
      check("f1_valid_count", valid_seen, exp_valid);

      // Frame 2: no spikes, traces decay.
      send_frame('0);
      idle_cycles(3);
      exp_valid = 2;
      check("f2_y1_3", y1_of(3), 16'hF000);
      check("f2_y2p_3", y2p_of(3), 16'hFFFF);
      check("f2_inhbt", o_inhbt, 0);
      check("f2_spike_buf", o_spike_buf, 0);
      check("f2_valid_count", valid_seen, exp_valid);
      check("f2_err_count", err_seen, exp_err);

      // Hazard forwarding: back-to-back idx 2, and idx 5 two accepts apart.
      drive(2, 1'b1, 1'b0, 1'b0);
      check("seq_err_t0", o_seq_err, 0);
      drive(2, 1'b0, 1'b0, 1'b0);
      check("seq_err_t1", o_seq_err, 1);
      drive(5, 1'b1, 1'b0, 1'b0);
      drive(6, 1'b0, 1'b0, 1'b0);
      drive(5, 1'b0, 1'b0, 1'b0);
      idle_cycles(3);
      exp_err += 5;
      check("fwd_y1_2", y1_of(2), 16'hF000);
      check("fwd_y2p_2", y2p_of(2), 16'hFFFF);
      check("fwd_y1_5", y1_of(5), 16'hF000);
      check("fwd_cnt_2", cnt_of(2), 1);

      // Sample init overrides spike on traces but the counter still counts.
      drive(7, 1'b1, 1'b0, 1'b0);
      drive(7, 1'b1, 1'b0, 1'b0);
      idle_cycles(3);
      check("pre_init_y1_7", y1_of(7), 16'hFFFF);
      check("pre_init_y2p_7", y2p_of(7), 16'hFFFF);
      drive(7, 1'b1, 1'b1, 1'b0);
      idle_cycles(3);
      exp_err += 3;
      check("init_y1_7", y1_of(7), 0);
      check("init_y2p_7", y2p_of(7), 0);
      check("init_cnt_7", cnt_of(7), 3);
      check("init_inhbt", o_inhbt, 5);

      // Out-of-range index: error strobe, nothing written.
      drive(20, 1'b1, 1'b0, 1'b0);
      idle_cycles(3);
      exp_err += 1;
      check("oor_inhbt", o_inhbt, 5);
      check("oor_spike_buf", o_spike_buf, 18'h00080);
      check("oor_err_count", err_seen, exp_err);

      // Partial frame 0..5 then 9: one error, no frame strobe.
      for (int i = 0; i <= 5; i++) drive(i, 1'b0, 1'b0, 1'b0);
      drive(9, 1'b0, 1'b0, 1'b0);
      idle_cycles(3);
      exp_err += 1;
      check("bad_err_count", err_seen, exp_err);
      check("bad_valid_count", valid_seen, exp_valid);
      check("bad_y1_3", y1_of(3), 16'hE100);
      check("bad_y2p_3", y2p_of(3), 16'hF800);

      // FSM must be back in IDLE: a clean frame completes without error.
      send_frame('0);
      idle_cycles(3);
      exp_valid += 1;
      check("clean_valid_count", valid_seen, exp_valid);
      check("clean_err_count", err_seen, exp_err);

      // Restart on idx 0 mid-frame.
      drive(0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0);
      drive(2, 1'b0, 1'b0, 1'b0);
      send_frame('0);
      idle_cycles(3);
      exp_valid += 1;
      exp_err += 1;
      check("restart_valid_count", valid_seen, exp_valid);
      check("restart_err_count", err_seen, exp_err);

      // 130 back-to-back all-spike frames saturate every counter.
      for (int f = 0; f < 130; f++) send_frame('1);
      idle_cycles(3);
      exp_valid += 130;
      for (int k = 0; k < N; k++) sat_vec[k*CNT_W +: CNT_W] = 7'd127;
      check("sat_cnt", o_post_cnt, sat_vec);
      check("sat_flag", o_cnt_sat, 1);
      check("sat_inhbt", o_inhbt, 18);
      check("sat_y1_17", y1_of(17), 16'hFFFF);
      check("sat_valid_count", valid_seen, exp_valid);

      // Clear beats a same-cycle increment.
      drive(0, 1'b1, 1'b0, 1'b1);
      idle_cycles(3);
      check("clr_cnt", o_post_cnt, 0);
      check("clr_flag", o_cnt_sat, 0);
      check("clr_inhbt", o_inhbt, 1);

      // Reset mid-frame after idx 8; idx 0 here restarts a collecting frame.
      for (int i = 0; i <= 8; i++) drive(i, 1'b1, 1'b0, 1'b0);
      exp_err += 1;
      rst_n = 1'b0;
      i_valid = 1'b0; i_spike = 1'b0;
      #2;
      check_all_zero("midrst");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      mask = '0; mask[4] = 1'b1; mask[11] = 1'b1;
      send_frame(mask);
      idle_cycles(3);
      exp_valid += 1;
      check("post_rst_valid_count", valid_seen, exp_valid);
      check("post_rst_err_count", err_seen, exp_err);
      check("post_rst_spike_buf", o_spike_buf, 18'h00810);
      check("post_rst_inhbt", o_inhbt, 2);
      check("post_rst_y1_4", y1_of(4), 16'hFFFF);
      check("post_rst_y1_8", y1_of(8), 0);
      check("post_rst_cnt_8", cnt_of(8), 0);
      check("post_rst_cnt_11", cnt_of(11), 1);
`ifdef POST_WTA_EN
      check("wta_idx", o_winner_idx, 4);
      check("wta_vld", o_winner_vld, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/post_trace_buffer.md
# post_trace_buffer

Parametrised post-synaptic state buffer for the time-multiplexed LIF neuron array. It takes one neuron result per cycle from the neuron core (index, spike), and for every neuron it maintains two exponentially decaying STDP traces, the previous-step y2 trace, a saturating spike counter, and a frame spike vector. Per-frame outputs are a lateral-inhibition count and a frame-complete strobe. A sequencing FSM checks index order and flags malformed frames to the learning controller.

## Interface
- N_NEURON, 18, neurons per frame (≥2)
- TRACE_W, 16, trace width, unsigned
- CNT_W, 7, post-spike counter width
- TAU1_SHIFT, 4, y1 decay shift (1..TRACE_W-1)
- TAU2_SHIFT, 5, y2 decay shift (1..TRACE_W-1)
- IDX_W, $clog2(N_NEURON), index width (derived, not overridden)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  neuron result valid; accepted every cycle it is high
- i_idx  in  IDX_W  neuron index of the result
- i_spike  in  1  neuron fired
- i_s_init  in  1  sample init; when accepted, clears the traces of i_idx instead of updating them
- i_cnt_clr  in  1  synchronous clear of all post counters
- o_spike_buf  out  N_NEURON  bit k = spike of neuron k in the current/last frame
- o_y1_trace  out  N_NEURON*TRACE_W  y1 traces, neuron k at [k*TRACE_W +: TRACE_W]
- o_y2_prev  out  N_NEURON*TRACE_W  y2 value before its most recent update
- o_post_cnt  out  N_NEURON*CNT_W  spike counters
- o_inhbt  out  IDX_W+1  spikes counted so far in the frame
- o_valid  out  1  one-cycle frame-complete strobe
- o_seq_err  out  1  one-cycle sequencing error strobe
- o_cnt_sat  out  1  high while any counter equals 2^CNT_W-1

## Operation
- Two-stage pipeline. S1 registers idx, spike, init, and the old y1/y2 of idx. S2 computes and writes the traces.
- Trace update in S2:
  - spike: y ← all-ones.
  - no spike: y ← y − (y >> TAUx_SHIFT), in TRACE_W bits. This never underflows.
  - init: y1, y2 and y2_prev ← 0. Init overrides spike.
  - Whenever the traces are updated (not on init), y2_prev ← old y2.
- Hazard: if the S2 index equals the S1 index, S1 forwards the S2 result in place of the array read.
- Spike buffer: bit i_idx ← i_spike on accept. It is not cleared between frames.
- Inhibition: on accept with idx 0, o_inhbt ← spike. Otherwise o_inhbt increments on spike.
- Counters:
  - On accept, counter[idx] increments on spike and saturates at 2^CNT_W-1.
  - i_cnt_clr has priority over a same-cycle increment, for all neurons.
- FSM states IDLE and COLLECT. `exp` holds the expected next index.
  - IDLE: accept of idx 0 → COLLECT, exp=1. Accept of any other idx → o_seq_err, stay in IDLE.
  - COLLECT: accept of idx==exp → exp+1. If idx==N_NEURON-1 → IDLE and o_valid is scheduled.
  - COLLECT: accept of idx 0 → o_seq_err, restart the frame (COLLECT, exp=1).
  - COLLECT: accept of any other wrong idx → o_seq_err, go to IDLE, and no o_valid for that frame.
- idx ≥ N_NEURON: o_seq_err. Nothing is written, and the FSM goes to IDLE.
- Out-of-order results that are in range are still applied to the state. Only the frame strobe is withheld.
- Reset: all registers, traces, counters, and outputs clear to 0, and the FSM enters IDLE. A reset mid-frame discards that frame.

## Timing
- Accept at edge t. Spike buffer, counter, and o_inhbt are visible after edge t+1. Traces are visible after edge t+2.
- o_valid is high for the one cycle after edge t+2, where t is the accept of idx N_NEURON-1. All outputs are final for the frame during that cycle.
- o_seq_err is high for the one cycle after edge t+1.
- A new frame may start in the cycle immediately after the last index. There are no bubbles, and back-to-back frames are supported.

## Configuration
- POST_WTA_EN defined:
  - Adds o_winner_idx (IDX_W) and o_winner_vld (1).
  - These are registered together with o_valid and hold until the next o_valid.
  - Winner = lowest index that spiked in the frame. vld=0 if no neuron spiked.
  - Both reset to 0.
- POST_WTA_EN undefined: the ports and logic are absent, and all other behaviour is identical.

## Structure
- Package snn_post_pkg holds:
  - the FSM state enum (IDLE, COLLECT);
  - a function computing the all-ones trace constant;
  - a function computing the saturating counter maximum.
- Sub-module post_trace_decay: the combinational decay/set/clear datapath, instantiated twice (y1 and y2) and parametrised by TRACE_W and shift.

## Test plan
- Defaults. Frame 1: spike only at idx 3. Frame 2: no spikes. → After frame 1, y1[3]=0xFFFF and o_inhbt=1. After frame 2, y1[3]=0xF000, y2[3]=0xF800, y2_prev[3]=0xFFFF, and o_valid has pulsed twice.
- Every neuron spikes for 130 frames → all counters stop at 127 and o_cnt_sat=1. Assert i_cnt_clr together with a spike → counters=0.
- Frame with idx 0..5 then 9 → o_seq_err pulses once, no o_valid, and the FSM is in IDLE. The next 0..17 frame → o_valid.
- Back-to-back accepts of idx 2 with spike=1 then 0 → forwarding applies, and y1[2]=0xF000, not a stale value.
- i_s_init with spike=1 at idx 7 → y1[7]=y2[7]=y2_prev[7]=0, but counter[7] increments.
- Assert reset mid-frame after idx 8, then a full frame → all outputs are 0 during reset and the following frame completes normally. With POST_WTA_EN, spikes at 4 and 11 → o_winner_idx=4 and o_winner_vld=1.
